// File: rtl/hazard_stall_controller.sv
// Hazard / stall sequencer sitting beside the decode stage.
// Detects load-use hazards against EX, freezes the front pipe while the
// memory stage runs a multi-cycle access, and flushes IF/ID and ID/EX on
// taken conditional jumps. Outputs are Mealy: RUN reacts to inputs in the
// same cycle, MEM_WAIT and FLUSH extend the entry cycle by a down-counter.
module hazard_stall_controller #(
    parameter int REG_ADDR_W       = 3,
    parameter int MEM_STALL_CYCLES = 2,
    parameter int FLUSH_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] dec_src1,
    input  logic                  dec_src1_valid,
    input  logic [REG_ADDR_W-1:0] dec_src2,
    input  logic                  dec_src2_valid,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_mem_read,
    input  logic                  ex_wb,
    input  logic                  mem_busy_req,
    input  logic                  jump_occured,
    input  logic                  direct_jump,
    output logic                  pc_write_en,
    output logic                  ifid_write_en,
    output logic                  idex_write_en,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic [1:0]            state,
    output logic [15:0]           stall_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10
    } state_t;

    // Counter only has to hold (cycles - 1), so clog2 of the larger count suffices.
    localparam int MAX_CYC = (MEM_STALL_CYCLES > FLUSH_CYCLES) ? MEM_STALL_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MEM_LOAD   = CNT_W'(MEM_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_count_q, stall_count_d;
    logic             load_use;

    // Load-use hazard: EX is loading a register that decode wants to read.
    assign load_use = ex_mem_read & ex_wb &
                      ((dec_src1_valid & (dec_src1 == ex_dst)) |
                       (dec_src2_valid & (dec_src2 == ex_dst)));

    // Next-state and Mealy pipeline controls; reset forces the safe NOP pattern.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        idex_write_en = 1'b1;
        idex_bubble   = 1'b0;
        ifid_flush    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_busy_req) begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_write_en = 1'b0;
                    if (MEM_STALL_CYCLES > 1) begin
                        state_d = ST_MEM_WAIT;
                        cnt_d   = MEM_LOAD;
                    end
                end else if (jump_occured) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (direct_jump) begin
                    // Only the wrong-path fetch is squashed; decode's own
                    // instruction still proceeds into ID/EX.
                    ifid_flush = 1'b1;
                end else if (load_use) begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    idex_bubble   = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // Everything else is ignored; a held jump is taken on return to RUN.
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                idex_write_en = 1'b0;
                cnt_d         = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                cnt_d       = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        if (!reset) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_write_en = 1'b1;
            idex_bubble   = 1'b1;
            ifid_flush    = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write_en && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // State, duration counter and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with default parameters
// (MEM_STALL_CYCLES=2, FLUSH_CYCLES=2). Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_hazard_stall_controller;

    logic        clk;
    logic        reset;
    logic [2:0]  dec_src1, dec_src2, ex_dst;
    logic        dec_src1_valid, dec_src2_valid;
    logic        ex_mem_read, ex_wb, mem_busy_req, jump_occured, direct_jump;
    logic        pc_write_en, ifid_write_en, idex_write_en, idex_bubble, ifid_flush;
    logic [1:0]  state;
    logic [15:0] stall_count;

    logic [4:0]  outs;
    int          checks;
    int          errors;
    logic [15:0] exp_stall;

    // {pc_en, ifid_en, idex_en, bubble, flush}
    localparam logic [4:0] O_RESET  = 5'b00111;
    localparam logic [4:0] O_RUN    = 5'b11100;
    localparam logic [4:0] O_FREEZE = 5'b00000;
    localparam logic [4:0] O_FLUSH  = 5'b11111;
    localparam logic [4:0] O_LU     = 5'b00110;
    localparam logic [4:0] O_DJ     = 5'b11101;

    assign outs = {pc_write_en, ifid_write_en, idex_write_en, idex_bubble, ifid_flush};

    hazard_stall_controller dut (
        .clk            (clk),
        .reset          (reset),
        .dec_src1       (dec_src1),
        .dec_src1_valid (dec_src1_valid),
        .dec_src2       (dec_src2),
        .dec_src2_valid (dec_src2_valid),
        .ex_dst         (ex_dst),
        .ex_mem_read    (ex_mem_read),
        .ex_wb          (ex_wb),
        .mem_busy_req   (mem_busy_req),
        .jump_occured   (jump_occured),
        .direct_jump    (direct_jump),
        .pc_write_en    (pc_write_en),
        .ifid_write_en  (ifid_write_en),
        .idex_write_en  (idex_write_en),
        .idex_bubble    (idex_bubble),
        .ifid_flush     (ifid_flush),
        .state          (state),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic mb, input logic jo, input logic dj,
                         input logic mr, input logic wb, input logic [2:0] dst,
                         input logic [2:0] s1, input logic s1v,
                         input logic [2:0] s2, input logic s2v);
        mem_busy_req   = mb;
        jump_occured   = jo;
        direct_jump    = dj;
        ex_mem_read    = mr;
        ex_wb          = wb;
        ex_dst         = dst;
        dec_src1       = s1;
        dec_src1_valid = s1v;
        dec_src2       = s2;
        dec_src2_valid = s2v;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        #12;
        checks++;
        if (outs !== O_RESET || state !== 2'b00 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold outs=%b state=%b cnt=%0d want outs=%b state=00 cnt=0",
                     outs, state, stall_count, O_RESET);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== O_RUN || state !== 2'b00 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_release outs=%b state=%b cnt=%0d want outs=%b state=00 cnt=0",
                     outs, state, stall_count, O_RUN);
        end
        exp_stall = 16'd0;
        $display("test_reset: outs=%b state=%b stall=%0d", outs, state, stall_count);
    endtask

    task automatic test_load_use();
        // src2 match
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 3'd3, 3'd1, 1, 3'd3, 1);
        #1;
        checks++;
        if (outs !== O_LU || state !== 2'b00) begin
            errors++;
            $display("FAIL load_use_src2 outs=%b state=%b want outs=%b state=00", outs, state, O_LU);
        end
        exp_stall = exp_stall + 16'd1;
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (outs !== O_RUN || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL load_use_clear outs=%b cnt=%0d want outs=%b cnt=%0d",
                     outs, stall_count, O_RUN, exp_stall);
        end
        // src1 match
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 3'd6, 3'd6, 1, 3'd2, 0);
        #1;
        checks++;
        if (outs !== O_LU) begin
            errors++;
            $display("FAIL load_use_src1 outs=%b want %b", outs, O_LU);
        end
        exp_stall = exp_stall + 16'd1;
        $display("test_load_use: outs=%b stall_exp=%0d", outs, exp_stall);
    endtask

    task automatic test_no_hazard();
        logic [4:0] want;
        // Each row: {mr, wb, s1v, s2v} with dst=5, src1=5, src2=5
        logic [3:0] rows [4] = '{4'b0111, 4'b1011, 4'b1100, 4'b1110};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 0, 0, rows[i][3], rows[i][2], 3'd5, 3'd5, rows[i][1], 3'd5, rows[i][0]);
            want = (i == 3) ? O_LU : O_RUN;
            #1;
            checks++;
            if (outs !== want) begin
                errors++;
                $display("FAIL no_hazard_%0d outs=%b want %b", i, outs, want);
            end
            if (i == 3) exp_stall = exp_stall + 16'd1;
            $display("test_no_hazard[%0d]: outs=%b", i, outs);
        end
        // mismatched register, both valid
        @(negedge clk);
        drive(0, 0, 0, 1, 1, 3'd4, 3'd2, 1, 3'd7, 1);
        #1;
        checks++;
        if (outs !== O_RUN || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL no_hazard_mismatch outs=%b cnt=%0d want outs=%b cnt=%0d",
                     outs, stall_count, O_RUN, exp_stall);
        end
    endtask

    task automatic test_mem_stall();
        @(negedge clk);
        drive(1, 0, 0, 1, 1, 3'd3, 3'd3, 1, 3'd3, 1); // load-use masked by memory stall
        #1;
        checks++;
        if (outs !== O_FREEZE || state !== 2'b00) begin
            errors++;
            $display("FAIL mem_entry outs=%b state=%b want outs=%b state=00", outs, state, O_FREEZE);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (outs !== O_FREEZE || state !== 2'b01) begin
            errors++;
            $display("FAIL mem_wait outs=%b state=%b want outs=%b state=01", outs, state, O_FREEZE);
        end
        exp_stall = exp_stall + 16'd2;
        @(negedge clk);
        #1;
        checks++;
        if (outs !== O_RUN || state !== 2'b00 || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL mem_exit outs=%b state=%b cnt=%0d want outs=%b state=00 cnt=%0d",
                     outs, state, stall_count, O_RUN, exp_stall);
        end
        $display("test_mem_stall: state=%b stall=%0d", state, stall_count);
    endtask

    task automatic test_mem_then_jump();
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        #1;
        checks++;
        if (outs !== O_FREEZE || state !== 2'b00) begin
            errors++;
            $display("FAIL mj_entry outs=%b state=%b want outs=%b state=00", outs, state, O_FREEZE);
        end
        @(negedge clk);
        mem_busy_req = 1'b0; // jump held by upstream
        #1;
        checks++;
        if (outs !== O_FREEZE || state !== 2'b01) begin
            errors++;
            $display("FAIL mj_wait outs=%b state=%b want outs=%b state=01", outs, state, O_FREEZE);
        end
        exp_stall = exp_stall + 16'd2;
        @(negedge clk);
        #1;
        checks++;
        if (outs !== O_FLUSH || state !== 2'b00) begin
            errors++;
            $display("FAIL mj_flush1 outs=%b state=%b want outs=%b state=00", outs, state, O_FLUSH);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0); // mem request ignored in FLUSH
        #1;
        checks++;
        if (outs !== O_FLUSH || state !== 2'b10) begin
            errors++;
            $display("FAIL mj_flush2 outs=%b state=%b want outs=%b state=10", outs, state, O_FLUSH);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (outs !== O_RUN || state !== 2'b00 || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL mj_exit outs=%b state=%b cnt=%0d want outs=%b state=00 cnt=%0d",
                     outs, state, stall_count, O_RUN, exp_stall);
        end
        $display("test_mem_then_jump: state=%b stall=%0d", state, stall_count);
    endtask

    task automatic test_direct_jump();
        @(negedge clk);
        drive(0, 0, 1, 1, 1, 3'd2, 3'd2, 1, 3'd0, 0);
        #1;
        checks++;
        if (outs !== O_DJ || state !== 2'b00) begin
            errors++;
            $display("FAIL direct_jump outs=%b state=%b want outs=%b state=00", outs, state, O_DJ);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (outs !== O_RUN || state !== 2'b00 || stall_count !== exp_stall) begin
            errors++;
            $display("FAIL direct_jump_after outs=%b state=%b cnt=%0d want outs=%b state=00 cnt=%0d",
                     outs, state, stall_count, O_RUN, exp_stall);
        end
        $display("test_direct_jump: outs=%b stall=%0d", outs, stall_count);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (state !== 2'b01) begin
            errors++;
            $display("FAIL rmw_wait state=%b want 01", state);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== O_RESET || state !== 2'b00 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rmw_async outs=%b state=%b cnt=%0d want outs=%b state=00 cnt=0",
                     outs, state, stall_count, O_RESET);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_stall = 16'd0;
        @(negedge clk);
        #1;
        checks++;
        if (outs !== O_RUN || state !== 2'b00 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rmw_release outs=%b state=%b cnt=%0d want outs=%b state=00 cnt=0",
                     outs, state, stall_count, O_RUN);
        end
        $display("test_reset_mid_wait: state=%b stall=%0d", state, stall_count);
    endtask

    task automatic test_saturate();
        @(negedge clk);
        mem_busy_req = 1'b1;
        repeat (70000) @(negedge clk);
        #1;
        checks++;
        if (stall_count !== 16'hFFFF || outs !== O_FREEZE) begin
            errors++;
            $display("FAIL saturate cnt=%h outs=%b want cnt=ffff outs=%b", stall_count, outs, O_FREEZE);
        end
        mem_busy_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (stall_count !== 16'hFFFF || outs !== O_RUN) begin
            errors++;
            $display("FAIL saturate_hold cnt=%h outs=%b want cnt=ffff outs=%b", stall_count, outs, O_RUN);
        end
        $display("test_saturate: stall=%h", stall_count);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 16'd0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mem_stall();
        test_mem_then_jump();
        test_direct_jump();
        test_reset_mid_wait();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
